muldiv_controller: RTL and testbench
====================================

MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port StartE, input, 1 bit: the execute-stage instruction is MUL-class; held high while that instruction sits in execute.
REQ-005 The block SHALL have port MulDivOpE, input, 2 bits: 00 MUL (low product), 01 MULHU (high product), 10 DIVU, 11 REMU; all unsigned.
REQ-006 The block SHALL have ports SrcAE and SrcBE, inputs, DATA_WIDTH bits each: forwarded operands A (multiplicand/dividend) and B (multiplier/divisor).
REQ-007 The block SHALL have port RdE, input, 5 bits: destination register of the request.
REQ-008 The block SHALL have port FlushE, input, 1 bit: abort the current request.
REQ-009 The block SHALL have port StallE, output, 1 bit: freeze the fetch, decode and execute pipeline registers.
REQ-010 The block SHALL have port DoneE, output, 1 bit: ResultE is valid for one cycle.
REQ-011 The block SHALL have port ResultE, output, DATA_WIDTH bits: the operation result.
REQ-012 The block SHALL have port BusyRd, output, 5 bits: the latched RdE while an operation is in flight, else 0.

Function
REQ-013 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 In IDLE, when StartE=1 and FlushE=0, the block SHALL latch SrcAE, SrcBE, MulDivOpE and RdE, and SHALL load a bit counter with DATA_WIDTH.
- On the next edge the state SHALL go to RUN.
- Exception: for DIVU/REMU with SrcBE=0 the state SHALL go directly to DONE.
REQ-015 RUN SHALL process one operand bit per cycle and decrement the counter.
- MUL/MULHU: shift-add into a 2*DATA_WIDTH accumulator.
- DIVU/REMU: restoring division with a DATA_WIDTH+1 remainder.
- When the counter reaches 0, the state SHALL go to DONE; RUN therefore lasts exactly DATA_WIDTH cycles.
REQ-016 DONE SHALL last exactly one cycle, then the state SHALL return to IDLE unconditionally.
- StartE high in DONE SHALL NOT start a new operation.
REQ-017 StallE SHALL equal (IDLE and StartE and not FlushE) or RUN; it SHALL be 0 in DONE.
- Latency: accept cycle T, DoneE in cycle T+DATA_WIDTH+1, stall cycles T..T+DATA_WIDTH.
- Divide-by-zero latency: DoneE in cycle T+1.
REQ-018 DoneE SHALL equal (state==DONE and not FlushE).
REQ-019 ResultE SHALL be driven only in DONE and SHALL be 0 in all other states. Values:
- MUL = product[DATA_WIDTH-1:0]
- MULHU = product[2*DATA_WIDTH-1:DATA_WIDTH]
- DIVU = quotient
- REMU = remainder
REQ-020 Divide by zero SHALL give DIVU = all ones and REMU = SrcAE.
REQ-021 Arithmetic SHALL be modulo 2^DATA_WIDTH per result field, with no overflow flag.
REQ-022 FlushE=1 in RUN SHALL force IDLE on the next edge with no DoneE.
- FlushE=1 in IDLE SHALL prevent acceptance.
- FlushE=1 in DONE SHALL suppress DoneE; the state still returns to IDLE.
REQ-023 BusyRd SHALL equal the latched Rd in RUN and DONE, and 0 in IDLE.
REQ-024 Operand inputs SHALL be ignored after acceptance; changes in RUN SHALL NOT affect the result.

Reset
REQ-025 When rst_n=0 at a rising clk edge, the block SHALL enter IDLE and clear the counter, accumulator, remainder and latched fields.
REQ-026 While in reset and in the cycle after reset, the outputs SHALL be StallE=0 (unless StartE=1), DoneE=0, ResultE=0 and BusyRd=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no DoneE.

Verification
REQ-028 MUL: SrcA=0x0001_0003, SrcB=0x0002_0005, StartE held high -> StallE high for 33 cycles; DoneE in cycle 34; ResultE=0x000B_000F.
REQ-029 MULHU: SrcA=SrcB=0xFFFF_FFFF -> ResultE=0xFFFF_FFFE at DoneE.
REQ-030 DIVU/REMU: DIVU 100/7 -> ResultE=14; REMU 100/7 -> ResultE=2; each with 32 RUN cycles.
REQ-031 Divide by zero: DIVU 5/0 -> DoneE in cycle 2, ResultE=0xFFFF_FFFF; REMU 5/0 -> ResultE=5; StallE high for 1 cycle only.
REQ-032 Abort: FlushE pulsed at RUN cycle 10 -> IDLE next cycle, no DoneE, BusyRd=0. Separately, rst_n=0 at RUN cycle 20 -> same outcome.
REQ-033 Back-to-back: two MUL requests with StartE high continuously (new operands after DoneE) -> exactly two DoneE pulses, 34 cycles apart, each with the correct result.

Source files
------------

// File: rtl/muldiv_controller_if.sv
`default_nettype none
// ============================================================================
// muldiv_controller_if : execute-stage request/response bundle for the muldiv unit
// Revision: 1.0
// ============================================================================
interface muldiv_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  StartE;
    logic [1:0]            MulDivOpE;
    logic [DATA_WIDTH-1:0] SrcAE;
    logic [DATA_WIDTH-1:0] SrcBE;
    logic [4:0]            RdE;
    logic                  FlushE;
    logic                  StallE;
    logic                  DoneE;
    logic [DATA_WIDTH-1:0] ResultE;
    logic [4:0]            BusyRd;

    modport master (
        output StartE, MulDivOpE, SrcAE, SrcBE, RdE, FlushE,
        input  StallE, DoneE, ResultE, BusyRd
    );

    modport slave (
        input  StartE, MulDivOpE, SrcAE, SrcBE, RdE, FlushE,
        output StallE, DoneE, ResultE, BusyRd
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_controller.sv
`default_nettype none
// ============================================================================
// muldiv_controller : iterative unsigned MUL/MULHU/DIVU/REMU, one bit per cycle
// Revision: 1.0
// ============================================================================
module muldiv_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    muldiv_controller_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_MULHU = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_REMU  = 2'd3;

    logic [1:0]              state;
    logic [CW-1:0]           count;
    // Multiply: full product. Divide: low half holds dividend shifting into quotient.
    logic [2*DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH:0]     rem;
    logic [DATA_WIDTH-1:0]   opa;
    logic [DATA_WIDTH-1:0]   opb;
    logic [1:0]              op;
    logic [4:0]              rd;

    logic                    accept;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH:0]     div_shift;
    logic [DATA_WIDTH:0]     div_diff;
    logic [DATA_WIDTH-1:0]   result;

    assign accept    = (state == IDLE) && bus.StartE && !bus.FlushE;
    assign mul_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, (acc[0] ? opa : '0)};
    assign div_shift = {rem[DATA_WIDTH-1:0], acc[DATA_WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            rem   <= '0;
            opa   <= '0;
            opb   <= '0;
            op    <= OP_MUL;
            rd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opa   <= bus.SrcAE;
                        opb   <= bus.SrcBE;
                        op    <= bus.MulDivOpE;
                        rd    <= bus.RdE;
                        count <= CW'(DATA_WIDTH);
                        rem   <= '0;
                        state <= RUN;
                        if (!bus.MulDivOpE[1]) begin
                            acc <= {{DATA_WIDTH{1'b0}}, bus.SrcBE};
                        end else if (bus.SrcBE == '0) begin
                            // Divide by zero resolves immediately: quotient all ones, remainder = dividend.
                            acc   <= {{DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b1}}};
                            rem   <= {1'b0, bus.SrcAE};
                            state <= DONE;
                        end else begin
                            acc <= {{DATA_WIDTH{1'b0}}, bus.SrcAE};
                        end
                    end
                end
                RUN: begin
                    if (bus.FlushE) begin
                        state <= IDLE;
                    end else begin
                        count <= count - CW'(1);
                        if (op[1]) begin
                            // Restoring step: keep the trial subtraction only if it did not borrow.
                            if (div_diff[DATA_WIDTH]) begin
                                rem                <= div_shift;
                                acc[DATA_WIDTH-1:0] <= {acc[DATA_WIDTH-2:0], 1'b0};
                            end else begin
                                rem                <= div_diff;
                                acc[DATA_WIDTH-1:0] <= {acc[DATA_WIDTH-2:0], 1'b1};
                            end
                        end else begin
                            acc <= {mul_sum, acc[DATA_WIDTH-1:1]};
                        end
                        if (count == CW'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        result = '0;
        case (op)
            OP_MUL:   result = acc[DATA_WIDTH-1:0];
            OP_MULHU: result = acc[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIVU:  result = acc[DATA_WIDTH-1:0];
            OP_REMU:  result = rem[DATA_WIDTH-1:0];
            default:  result = '0;
        endcase
    end

    assign bus.StallE  = accept || (state == RUN);
    assign bus.DoneE   = (state == DONE) && !bus.FlushE;
    assign bus.ResultE = (state == DONE) ? result : '0;
    assign bus.BusyRd  = ((state == RUN) || (state == DONE)) ? rd : 5'd0;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_controller.sv
`default_nettype none
// ============================================================================
// tb_muldiv_controller : scoreboard bench with directed muldiv vectors
// Revision: 1.0
// ============================================================================
module tb_muldiv_controller;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_controller_if #(.DATA_WIDTH(DW)) bus ();
    muldiv_controller #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [DW-1:0] result;
        int            accept;
        int            lat;
        string         name;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   d1, d2, dx;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every DoneE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.DoneE === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_result"}, 64'(bus.ResultE), 64'(e.result));
                check({e.name, "_latency"}, 64'(cyc - e.accept), 64'(e.lat));
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] res, input int lat,
                          input bit keep, output int done_cyc);
        int stalls = 0;
        bit seen   = 1'b0;
        logic [4:0] rd;
        rd = 5'(op) + 5'd10;
        @(posedge clk); #1;
        bus.StartE = 1'b1; bus.MulDivOpE = op; bus.SrcAE = a; bus.SrcBE = b; bus.RdE = rd;
        sbq.push_back('{res, cyc, lat, name});
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (bus.StallE === 1'b1) stalls++;
            if (n == 1) begin
                check({name, "_busyrd"}, 64'(bus.BusyRd), 64'(rd));
                bus.SrcAE = a ^ 32'h5A5A_A5A5;
                bus.SrcBE = b ^ 32'h0F0F_F0F1;
            end
            if (bus.DoneE === 1'b1) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
        check({name, "_stalls"}, 64'(stalls), 64'(lat));
        done_cyc = cyc;
        if (!keep) begin
            @(posedge clk); #1;
            bus.StartE = 1'b0;
        end
    endtask

    task automatic abort_test(input string name, input bit use_reset, input int at_run);
        @(posedge clk); #1;
        bus.StartE = 1'b1; bus.MulDivOpE = 2'd0; bus.SrcAE = 32'd1234; bus.SrcBE = 32'd99;
        bus.RdE = 5'd21;
        repeat (at_run) @(posedge clk);
        @(negedge clk);
        check({name, "_busy_in_run"}, 64'(bus.BusyRd), 64'd21);
        check({name, "_stall_in_run"}, 64'(bus.StallE), 64'd1);
        @(posedge clk); #1;
        bus.StartE = 1'b0;
        if (use_reset) rst_n = 1'b0;
        else bus.FlushE = 1'b1;
        @(posedge clk); #1;
        bus.FlushE = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check({name, "_busy_after"}, 64'(bus.BusyRd), 64'd0);
        check({name, "_stall_after"}, 64'(bus.StallE), 64'd0);
        check({name, "_done_after"}, 64'(bus.DoneE), 64'd0);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.StartE = 1'b0; bus.MulDivOpE = 2'd0; bus.SrcAE = '0; bus.SrcBE = '0;
        bus.RdE = '0; bus.FlushE = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_stall", 64'(bus.StallE), 64'd0);
        check("reset_done", 64'(bus.DoneE), 64'd0);
        check("reset_result", 64'(bus.ResultE), 64'd0);
        check("reset_busyrd", 64'(bus.BusyRd), 64'd0);

        run_op("mul",       2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 33, 1'b0, dx);
        run_op("mulhu",     2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, dx);
        run_op("mul_wrap",  2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0, dx);
        run_op("divu",      2'd2, 32'd100,       32'd7,         32'd14,        33, 1'b0, dx);
        run_op("remu",      2'd3, 32'd100,       32'd7,         32'd2,         33, 1'b0, dx);
        run_op("divu_small",2'd2, 32'd3,         32'd5,         32'd0,         33, 1'b0, dx);
        run_op("remu_max",  2'd3, 32'hFFFF_FFFF, 32'd16,        32'hF,         33, 1'b0, dx);
        run_op("divu_one",  2'd2, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 1'b0, dx);
        run_op("divu_zero", 2'd2, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0, dx);
        run_op("remu_zero", 2'd3, 32'd5,         32'd0,         32'd5,         1,  1'b0, dx);

        abort_test("flush", 1'b0, 10);
        abort_test("reset", 1'b1, 20);

        run_op("b2b_first",  2'd0, 32'd7,       32'd6,     32'd42,        33, 1'b1, d1);
        run_op("b2b_second", 2'd0, 32'h12345,   32'h100,   32'h0123_4500, 33, 1'b0, d2);
        check("b2b_gap", 64'(d2 - d1), 64'd34);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
